// File: rtl/date_counter_cal.sv
// Registered calendar date counter: day/month/year with day-of-year and weekday
// tracking, validated loading, selectable Gregorian/Julian leap rule and year wrap.
module date_counter_cal #(
    parameter int CALENDAR   = 0,
    parameter int YEAR_W     = 11,
    parameter int RESET_YEAR = 2000,
    parameter int RESET_WDAY = 6
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              load,
    input  logic [5:0]        loadDay,
    input  logic [3:0]        loadMonth,
    input  logic [YEAR_W-1:0] loadYear,
    input  logic [2:0]        loadWeekday,
    input  logic              tick,
    output logic [5:0]        dayOfMonth,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [8:0]        dayOfYear,
    output logic [2:0]        weekday,
    output logic              leap,
    output logic              loadErr,
    output logic              yearWrap
);

    localparam logic [YEAR_W-1:0] YEAR_MAX = {YEAR_W{1'b1}};

    function automatic logic is_leap_f(input logic [YEAR_W-1:0] y);
        int unsigned yi;
        logic        div4;
        logic        div100;
        logic        div400;
        yi     = 32'(y);
        div4   = (yi % 4)   == 0;
        div100 = (yi % 100) == 0;
        div400 = (yi % 400) == 0;
        if (CALENDAR == 1)
            return div4;
        else
            return div4 && (!div100 || div400);
    endfunction

    function automatic logic [5:0] month_len_f(input logic [3:0] m, input logic lp);
        logic [5:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 6'd30;
            4'd2:                    len = lp ? 6'd29 : 6'd28;
            default:                 len = 6'd31;
        endcase
        return len;
    endfunction

    // Days in a common year that precede the first of month m.
    function automatic logic [8:0] days_before_f(input logic [3:0] m);
        logic [8:0] d;
        case (m)
            4'd2:    d = 9'd31;
            4'd3:    d = 9'd59;
            4'd4:    d = 9'd90;
            4'd5:    d = 9'd120;
            4'd6:    d = 9'd151;
            4'd7:    d = 9'd181;
            4'd8:    d = 9'd212;
            4'd9:    d = 9'd243;
            4'd10:   d = 9'd273;
            4'd11:   d = 9'd304;
            4'd12:   d = 9'd334;
            default: d = 9'd0;
        endcase
        return d;
    endfunction

    logic [5:0]        day_reg,   day_next;
    logic [3:0]        month_reg, month_next;
    logic [YEAR_W-1:0] year_reg,  year_next;
    logic [8:0]        doy_reg,   doy_next;
    logic [2:0]        wday_reg,  wday_next;
    logic              load_err_reg, load_err_next;
    logic              year_wrap_reg, year_wrap_next;

    logic              cur_leap;
    logic [5:0]        cur_len;
    logic              load_leap;
    logic [5:0]        load_len;
    logic              load_ok;
    logic [8:0]        load_doy;

    assign cur_leap  = is_leap_f(year_reg);
    assign cur_len   = month_len_f(month_reg, cur_leap);
    assign load_leap = is_leap_f(loadYear);
    assign load_len  = month_len_f(loadMonth, load_leap);

    assign load_ok = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) &&
                     (loadDay != 6'd0) && (loadDay <= load_len) &&
                     (loadWeekday <= 3'd6);

    assign load_doy = days_before_f(loadMonth) + {3'd0, loadDay} +
                      ((load_leap && loadMonth >= 4'd3) ? 9'd1 : 9'd0);

    always_comb begin
        day_next       = day_reg;
        month_next     = month_reg;
        year_next      = year_reg;
        doy_next       = doy_reg;
        wday_next      = wday_reg;
        load_err_next  = 1'b0;
        year_wrap_next = 1'b0;

        if (load) begin
            // A simultaneous tick is intentionally dropped: the loaded date wins.
            if (load_ok) begin
                day_next   = loadDay;
                month_next = loadMonth;
                year_next  = loadYear;
                doy_next   = load_doy;
                wday_next  = loadWeekday;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (tick) begin
            wday_next = (wday_reg >= 3'd6) ? 3'd0 : wday_reg + 3'd1;
            if (day_reg < cur_len) begin
                day_next = day_reg + 6'd1;
                doy_next = doy_reg + 9'd1;
            end else begin
                day_next = 6'd1;
                if (month_reg < 4'd12) begin
                    month_next = month_reg + 4'd1;
                    doy_next   = doy_reg + 9'd1;
                end else begin
                    month_next = 4'd1;
                    doy_next   = 9'd1;
                    if (year_reg == YEAR_MAX) begin
                        year_next      = '0;
                        year_wrap_next = 1'b1;
                    end else begin
                        year_next = year_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            day_reg       <= 6'd1;
            month_reg     <= 4'd1;
            year_reg      <= YEAR_W'(RESET_YEAR);
            doy_reg       <= 9'd1;
            wday_reg      <= 3'(RESET_WDAY);
            load_err_reg  <= 1'b0;
            year_wrap_reg <= 1'b0;
        end else begin
            day_reg       <= day_next;
            month_reg     <= month_next;
            year_reg      <= year_next;
            doy_reg       <= doy_next;
            wday_reg      <= wday_next;
            load_err_reg  <= load_err_next;
            year_wrap_reg <= year_wrap_next;
        end
    end

    assign dayOfMonth = day_reg;
    assign month      = month_reg;
    assign year       = year_reg;
    assign dayOfYear  = doy_reg;
    assign weekday    = wday_reg;
    assign leap       = cur_leap;
    assign loadErr    = load_err_reg;
    assign yearWrap   = year_wrap_reg;

endmodule

// File: tb/tb_date_counter_cal.sv
// Directed bench for date_counter_cal: calendar reference model checked every cycle
// plus hand-computed literal expectations for the key calendar boundaries.
module tb_date_counter_cal;

    localparam int CAL    = 0;
    localparam int YW     = 11;
    localparam int YMAX   = (1 << YW) - 1;

    logic          clk;
    logic          resetN;
    logic          load;
    logic [5:0]    loadDay;
    logic [3:0]    loadMonth;
    logic [YW-1:0] loadYear;
    logic [2:0]    loadWeekday;
    logic          tick;
    logic [5:0]    dayOfMonth;
    logic [3:0]    month;
    logic [YW-1:0] year;
    logic [8:0]    dayOfYear;
    logic [2:0]    weekday;
    logic          leap;
    logic          loadErr;
    logic          yearWrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_day, m_mon, m_year, m_wd;
    bit m_err, m_wrap;

    date_counter_cal #(
        .CALENDAR(CAL), .YEAR_W(YW), .RESET_YEAR(2000), .RESET_WDAY(6)
    ) dut (
        .clk(clk), .resetN(resetN), .load(load), .loadDay(loadDay),
        .loadMonth(loadMonth), .loadYear(loadYear), .loadWeekday(loadWeekday),
        .tick(tick), .dayOfMonth(dayOfMonth), .month(month), .year(year),
        .dayOfYear(dayOfYear), .weekday(weekday), .leap(leap),
        .loadErr(loadErr), .yearWrap(yearWrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_leap(input int y);
        if (CAL == 1) return (y % 4) == 0;
        return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
    endfunction

    function automatic int mlen(input int m, input int y);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && is_leap(y)) return 29;
        return lens[m-1];
    endfunction

    function automatic int day_of_year(input int d, input int m, input int y);
        int s = d;
        for (int k = 1; k < m; k++) s += mlen(k, y);
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on the same events the DUT does.
    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                m_day = 1; m_mon = 1; m_year = 2000; m_wd = 6;
                m_err = 0; m_wrap = 0;
            end else begin
                m_err = 0; m_wrap = 0;
                if (load) begin
                    if (loadMonth >= 1 && loadMonth <= 12 && loadDay >= 1 &&
                        int'(loadDay) <= mlen(int'(loadMonth), int'(loadYear)) &&
                        loadWeekday <= 6) begin
                        m_day = loadDay; m_mon = loadMonth;
                        m_year = loadYear; m_wd = loadWeekday;
                    end else begin
                        m_err = 1;
                    end
                end else if (tick) begin
                    m_wd = (m_wd + 1) % 7;
                    if (m_day < mlen(m_mon, m_year)) begin
                        m_day++;
                    end else begin
                        m_day = 1;
                        if (m_mon < 12) m_mon++;
                        else begin
                            m_mon = 1;
                            if (m_year == YMAX) begin
                                m_year = 0;
                                m_wrap = 1;
                            end else m_year++;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_day",  int'(dayOfMonth), m_day);
            check("cmp_mon",  int'(month),      m_mon);
            check("cmp_year", int'(year),       m_year);
            check("cmp_doy",  int'(dayOfYear),  day_of_year(m_day, m_mon, m_year));
            check("cmp_wd",   int'(weekday),    m_wd);
            check("cmp_leap", int'(leap),       int'(is_leap(m_year)));
            check("cmp_err",  int'(loadErr),    int'(m_err));
            check("cmp_wrap", int'(yearWrap),   int'(m_wrap));
        end
    end

    task automatic do_load(input int d, input int m, input int y, input int w);
        load        = 1'b1;
        loadDay     = 6'(d);
        loadMonth   = 4'(m);
        loadYear    = YW'(y);
        loadWeekday = 3'(w);
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #2;
        tick = 1'b0;
    endtask

    task automatic check_date(input string tag, input int d, input int m,
                              input int y, input int doy);
        check({tag, "_day"},  int'(dayOfMonth), d);
        check({tag, "_mon"},  int'(month),      m);
        check({tag, "_year"}, int'(year),       y);
        check({tag, "_doy"},  int'(dayOfYear),  doy);
    endtask

    initial begin
        resetN = 1'b0; load = 1'b0; tick = 1'b0;
        loadDay = '0; loadMonth = '0; loadYear = '0; loadWeekday = '0;
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;

        // Reset values
        check_date("reset", 1, 1, 2000, 1);
        check("reset_wd",   int'(weekday),  6);
        check("reset_leap", int'(leap),     1);
        check("reset_err",  int'(loadErr),  0);
        check("reset_wrap", int'(yearWrap), 0);
        @(posedge clk); #2;

        // Leap February 2016
        do_load(28, 2, 2016, 0);
        check_date("feb2016_load", 28, 2, 2016, 59);
        do_tick();
        check_date("feb2016_t1", 29, 2, 2016, 60);
        do_tick();
        check_date("feb2016_t2", 1, 3, 2016, 61);
        check("feb2016_wd", int'(weekday), 2);

        // 1900: century year, leap only under Julian rule
        do_load(28, 2, 1900, 3);
        do_tick();
        check_date("y1900", (CAL == 0) ? 1 : 29, (CAL == 0) ? 3 : 2, 1900,
                   (CAL == 0) ? 60 : 59);

        // Year wrap at 2047 -> 0
        do_load(31, 12, 2047, 3);
        check_date("wrap_load", 31, 12, 2047, 365);
        do_tick();
        check_date("wrap_tick", 1, 1, 0, 1);
        check("wrap_wd",    int'(weekday),  4);
        check("wrap_pulse", int'(yearWrap), 1);
        check("wrap_leap0", int'(leap),     1);
        @(posedge clk); #2;
        check("wrap_clear", int'(yearWrap), 0);

        // Rejected loads leave state untouched
        do_load(15, 6, 2010, 2);
        check_date("pre_err", 15, 6, 2010, 166);
        do_load(10, 14, 2011, 1);
        check("err_month", int'(loadErr), 1);
        do_load(33, 5, 2011, 1);
        check("err_day", int'(loadErr), 1);
        do_load(29, 2, 1999, 1);
        check("err_feb29", int'(loadErr), 1);
        do_load(1, 1, 2011, 7);
        check("err_wday", int'(loadErr), 1);
        check_date("post_err", 15, 6, 2010, 166);
        check("post_err_wd", int'(weekday), 2);
        @(posedge clk); #2;
        check("err_clear", int'(loadErr), 0);

        // load and tick together: load wins, no advance
        tick = 1'b1;
        do_load(10, 10, 2020, 6);
        tick = 1'b0;
        check_date("ld_tick", 10, 10, 2020, 284);
        check("ld_tick_wd", int'(weekday), 6);
        do_tick();
        check_date("ld_tick_next", 11, 10, 2020, 285);
        check("ld_tick_next_wd", int'(weekday), 0);

        // Long run across a leap year with idle gaps
        do_load(25, 12, 2023, 1);
        for (int i = 0; i < 900; i++) begin
            tick = (i % 5) != 4;
            @(posedge clk); #2;
        end

        // Asynchronous reset mid-run, checked between clock edges
        tick = 1'b1;
        #1 resetN = 1'b0;
        #1;
        check_date("async_rst", 1, 1, 2000, 1);
        check("async_rst_wd", int'(weekday), 6);
        tick = 1'b0;
        @(posedge clk); #2;
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_date("idle_hold", 1, 1, 2000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
